// File: rtl/iis_write_logic.sv
// I2S transmitter: 24-bit stereo, bclk = clk/32, lrclk = clk/2048.
// Underrun fill: define IIS_TX_REPEAT_EN to repeat the last frame, else send silence.
module iis_write_logic (
   input  logic        clk_100m,
   input  logic        rst_n,
   input  logic [23:0] ldata_in,
   input  logic [23:0] rdata_in,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        bclk,
   output logic        lrclk,
   output logic        sdata_o,
   output logic        underrun
);

   logic [10:0] cnt;
   logic [10:0] cnt_nxt;
   logic [47:0] hold;
   logic [47:0] frame;
   logic        full;
   logic        frame_end;
   logic        xfer;
   logic [4:0]  slot_nxt;
   logic [4:0]  idx;
   logic [23:0] word_nxt;
   logic        bit_nxt;

   assign cnt_nxt      = cnt + 11'd1;
   assign frame_end    = &cnt;
   assign sample_ready = !full && !frame_end;
   assign xfer         = sample_valid && sample_ready;
   assign underrun     = frame_end && !full;
   assign bclk         = cnt[4];
   assign lrclk        = cnt[10];

   // Bit for the slot that begins at the next bclk falling edge.
   always_comb begin
      slot_nxt = cnt_nxt[9:5];
      word_nxt = cnt_nxt[10] ? frame[23:0] : frame[47:24];
      idx      = 5'd24 - slot_nxt;
      bit_nxt  = 1'b0;
      if (slot_nxt >= 5'd1 && slot_nxt <= 5'd24)
         bit_nxt = word_nxt[idx];
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         sdata_o <= 1'b0;
         hold    <= '0;
         frame   <= '0;
         full    <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (&cnt[4:0])
            sdata_o <= bit_nxt;
         if (xfer) begin
            hold <= {ldata_in, rdata_in};
            full <= 1'b1;
         end
         if (frame_end) begin
            if (full) begin
               frame <= hold;
               full  <= 1'b0;
            end else begin
`ifdef IIS_TX_REPEAT_EN
               frame <= frame;
`else
               frame <= '0;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_iis_write_logic.sv
// Self-checking bench for iis_write_logic: frame-level model plus
// directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_iis_write_logic;

   logic        clk_100m = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] ldata_in = '0;
   logic [23:0] rdata_in = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic        bclk;
   logic        lrclk;
   logic        sdata_o;
   logic        underrun;

   int checks = 0;
   int errors = 0;

`ifdef IIS_TX_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   always #5 clk_100m = ~clk_100m;

   iis_write_logic dut (
      .clk_100m     (clk_100m),
      .rst_n        (rst_n),
      .ldata_in     (ldata_in),
      .rdata_in     (rdata_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata_o      (sdata_o),
      .underrun     (underrun)
   );

   // Model state: position in frame, word on the line, pending pairs.
   int          mcnt = 0;
   logic [23:0] ml = '0;
   logic [23:0] mr = '0;
   logic [47:0] mq[$];
   bit          mxfer = 1'b0;
   int          nfr = 0;
   int          unr = 0;
   logic [23:0] cap_l = '0;
   logic [23:0] cap_r = '0;
   logic [23:0] last_l = '0;
   logic [23:0] last_r = '0;

   int          s;
   bit          ch;
   logic [23:0] w;
   bit          e_sd;
   bit          e_rdy;
   bit          e_un;

   task automatic chk(input string name, input logic [47:0] act,
                      input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk_100m) begin
      if (!rst_n) begin
         chk("rst_bclk", bclk, 0);
         chk("rst_lrclk", lrclk, 0);
         chk("rst_sdata", sdata_o, 0);
         chk("rst_underrun", underrun, 0);
         mcnt = 0;
         mq.delete();
         ml = '0;
         mr = '0;
         cap_l = '0;
         cap_r = '0;
         mxfer = 1'b0;
      end else begin
         s     = (mcnt / 32) % 32;
         ch    = (mcnt >= 1024);
         w     = ch ? mr : ml;
         e_sd  = (s >= 1 && s <= 24) ? w[24-s] : 1'b0;
         e_rdy = (mq.size() == 0) && (mcnt != 2047);
         e_un  = (mcnt == 2047) && (mq.size() == 0);
         chk("bclk", bclk, ((mcnt % 32) >= 16));
         chk("lrclk", lrclk, ch);
         chk("sdata", sdata_o, e_sd);
         chk("ready", sample_ready, e_rdy);
         chk("underrun", underrun, e_un);
         if (underrun === 1'b1) unr++;
         if ((mcnt % 32) == 16 && s >= 1 && s <= 24) begin
            if (ch) cap_r[24-s] = sdata_o;
            else    cap_l[24-s] = sdata_o;
         end
         mxfer = sample_valid && e_rdy;
         if (mxfer) mq.push_back({ldata_in, rdata_in});
         if (mcnt == 2047) begin
            last_l = cap_l;
            last_r = cap_r;
            cap_l  = '0;
            cap_r  = '0;
            nfr++;
            if (mq.size() > 0) {ml, mr} = mq.pop_front();
            else if (!REP) begin
               ml = '0;
               mr = '0;
            end
         end
         mcnt = (mcnt + 1) % 2048;
      end
   end

   task automatic tick();
      @(posedge clk_100m);
      #1;
   endtask

   task automatic wait_frame_end();
      int f;
      f = nfr;
      for (int i = 0; i < 2100 && nfr == f; i++) tick();
      chk("frame_end_seen", (nfr != f), 1);
   endtask

   task automatic wait_cnt(input int t);
      for (int i = 0; i < 2100 && mcnt != t; i++) tick();
      chk("wait_cnt", mcnt, t);
   endtask

   task automatic send(input logic [23:0] l, input logic [23:0] r);
      ldata_in = l;
      rdata_in = r;
      sample_valid = 1'b1;
      for (int i = 0; i < 2100; i++) begin
         tick();
         if (mxfer) break;
      end
      chk("send_accept", mxfer, 1);
      sample_valid = 1'b0;
   endtask

   int          first_b;
   int          first_l;
   int          fall_l;
   int          nb;
   bit          pb;
   int          k;
   int          nx;
   int          u0;
   int          f0;
   int          pf;
   logic [23:0] lv[4];
   logic [23:0] rv[4];

   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk("ready_after_rst", sample_ready, 1);

      first_b = -1;
      first_l = -1;
      fall_l  = -1;
      nb = 0;
      pb = 1'b0;
      for (int i = 1; i <= 2100; i++) begin
         tick();
         if (bclk && !pb) nb++;
         pb = bclk;
         if (first_b < 0 && bclk) first_b = i;
         if (first_l < 0 && lrclk) first_l = i;
         if (first_l >= 0 && fall_l < 0 && !lrclk) begin
            fall_l = i;
            break;
         end
      end
      chk("first_bclk_rise", first_b, 16);
      chk("bclk_rises", nb, 64);
      chk("lrclk_rise", first_l, 1024);
      chk("lrclk_fall", fall_l, 2048);
      chk("first_underrun", unr, 1);
      chk("first_frame_l", last_l, 24'h0);
      chk("first_frame_r", last_r, 24'h0);

      send(24'hA5A5A5, 24'h123456);
      wait_frame_end();
      chk("no_underrun_full", unr, 1);

      k = 1;
      ldata_in = 24'(k);
      rdata_in = 24'hFFFFFF ^ 24'(k);
      sample_valid = 1'b1;
      nx = 0;
      u0 = unr;
      f0 = nfr;
      pf = nfr;
      for (int i = 0; i < 4 * 2048 + 50 && nfr < f0 + 4; i++) begin
         tick();
         if (mxfer) begin
            nx++;
            k++;
            ldata_in = 24'(k);
            rdata_in = 24'hFFFFFF ^ 24'(k);
         end
         if (nfr != pf) begin
            lv[nfr-f0-1] = last_l;
            rv[nfr-f0-1] = last_r;
            pf = nfr;
         end
      end
      sample_valid = 1'b0;
      chk("pair_l", lv[0], 24'hA5A5A5);
      chk("pair_r", rv[0], 24'h123456);
      chk("stream_l1", lv[1], 24'h000001);
      chk("stream_r1", rv[1], 24'hFFFFFE);
      chk("stream_l2", lv[2], 24'h000002);
      chk("stream_l3", lv[3], 24'h000003);
      chk("stream_xfers", nx, 4);
      chk("stream_no_underrun", unr, u0);

      send(24'h7FFFFF, 24'h000001);
      wait_frame_end();
      chk("stream_l4", last_l, 24'h000004);
      chk("stream_r4", last_r, 24'hFFFFFB);
      u0 = unr;
      wait_frame_end();
      chk("max_l", last_l, 24'h7FFFFF);
      chk("max_r", last_r, 24'h000001);
      chk("underrun_once", unr, u0 + 1);

      wait_cnt(2047);
      ldata_in = 24'h5A0F3C;
      rdata_in = 24'hC3B501;
      sample_valid = 1'b1;
      tick();
      chk("no_xfer_at_end", mxfer, 0);
      tick();
      chk("xfer_after_end", mxfer, 1);
      sample_valid = 1'b0;
      chk("fill_l", last_l, REP ? 24'h7FFFFF : 24'h0);
      chk("fill_r", last_r, REP ? 24'h000001 : 24'h0);
      chk("underrun_twice", unr, u0 + 2);
      wait_frame_end();
      chk("fill_again_l", last_l, REP ? 24'h7FFFFF : 24'h0);
      wait_frame_end();
      chk("late_l", last_l, 24'h5A0F3C);
      chk("late_r", last_r, 24'hC3B501);

      wait_cnt(1024 + 12 * 32 + 7);
      chk("pre_rst_lrclk", lrclk, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_bclk", bclk, 0);
      chk("async_lrclk", lrclk, 0);
      chk("async_sdata", sdata_o, 0);
      chk("async_underrun", underrun, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      u0 = unr;
      wait_frame_end();
      chk("post_rst_l", last_l, 24'h0);
      chk("post_rst_r", last_r, 24'h0);
      chk("post_rst_underrun", unr, u0 + 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
